// File: rtl/truth_table_bist_if.sv
// Request/result bundle between the BIST controller and its environment.
// The slave side is the controller; the master side supplies start and the block output.
interface truth_table_bist_if #(
    parameter int N_IN = 3
);
    logic                   start;
    logic [N_IN-1:0]        dut_in;
    logic                   dut_out;
    logic                   busy;
    logic                   done;
    logic                   pass;
    logic [(1<<N_IN)-1:0]   tt;
    logic [N_IN:0]          fail_count;
    logic [N_IN-1:0]        first_fail;

    modport master (
        output start, dut_out,
        input  dut_in, busy, done, pass, tt, fail_count, first_fail
    );

    modport slave (
        input  start, dut_out,
        output dut_in, busy, done, pass, tt, fail_count, first_fail
    );
endinterface

// File: rtl/truth_table_bist.sv
// Exhaustive truth-table self-test for a small N_IN-input, 1-output combinational block.
// Optional macro BIST_SYNC_EN adds a 2-flop synchronizer on dut_out (two extra settle cycles).
module truth_table_bist #(
    parameter int                   N_IN     = 3,
    parameter logic [(1<<N_IN)-1:0] EXPECTED = 8'h96,
    parameter int                   SETTLE   = 2
) (
    input logic               clk,
    input logic               reset,
    truth_table_bist_if.slave bus
);
    localparam int N_PAT = 1 << N_IN;
`ifdef BIST_SYNC_EN
    localparam int EFF_SETTLE = SETTLE + 2;
`else
    localparam int EFF_SETTLE = SETTLE;
`endif
    localparam int              CW     = (EFF_SETTLE > 1) ? $clog2(EFF_SETTLE) : 1;
    localparam logic [CW-1:0]   RELOAD = CW'(EFF_SETTLE - 1);
    localparam logic [N_IN-1:0] LAST   = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CW-1:0]     r_cnt;
    logic [N_IN-1:0]   r_dut_in;
    logic [N_IN-1:0]   r_first_fail;
    logic [N_PAT-1:0]  r_tt;
    logic [N_IN:0]     r_fail_count;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;

    logic              w_sample;
    logic              w_accept;
    logic              w_mismatch;
    logic              w_last;
    logic [N_IN:0]     w_fail_next;

`ifdef BIST_SYNC_EN
    logic [1:0] r_sync;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_sync <= '0;
        else       r_sync <= {r_sync[0], bus.dut_out};
    end
    assign w_sample = r_sync[1];
`else
    assign w_sample = bus.dut_out;
`endif

    assign w_accept    = bus.start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_mismatch  = (w_sample != EXPECTED[r_dut_in]);
    assign w_fail_next = r_fail_count + {{N_IN{1'b0}}, w_mismatch};
    assign w_last      = (r_dut_in == LAST);

    // NOTE: sequential state uses <= so every flop samples pre-edge values; blocking here would race.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // NOTE: defaulting w_next before the case keeps this block free of inferred latches.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (w_accept) w_next = S_SETTLE;
            S_SETTLE:       if (r_cnt == '0) w_next = S_SAMPLE;
            S_SAMPLE:       w_next = w_last ? S_DONE : S_SETTLE;
            default:        w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt        <= '0;
            r_dut_in     <= '0;
            r_first_fail <= '0;
            r_tt         <= '0;
            r_fail_count <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_cnt        <= RELOAD;
                        r_dut_in     <= '0;
                        r_first_fail <= '0;
                        r_tt         <= '0;
                        r_fail_count <= '0;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_pass       <= 1'b0;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                end
                S_SAMPLE: begin
                    r_tt[r_dut_in] <= w_sample;
                    r_fail_count   <= w_fail_next;
                    // Only the first mismatch of the sweep is recorded.
                    if (w_mismatch && r_fail_count == '0) r_first_fail <= r_dut_in;
                    if (w_last) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                        r_pass <= (w_fail_next == '0);
                    end else begin
                        r_dut_in <= r_dut_in + 1'b1;
                        r_cnt    <= RELOAD;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.dut_in     = r_dut_in;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.pass       = r_pass;
    assign bus.tt         = r_tt;
    assign bus.fail_count = r_fail_count;
    assign bus.first_fail = r_first_fail;
endmodule

// File: tb/tb_truth_table_bist.sv
// Directed bench for truth_table_bist: XOR, stuck-at-0 and stuck-at-1 block models,
// ignored mid-sweep start, async reset abort and restart from DONE.
module tb_truth_table_bist;
`ifdef BIST_SYNC_EN
    localparam int PER = 2 + 3;
`else
    localparam int PER = 2 + 1;
`endif
    localparam int LAT = 8 * PER;

    logic clk;
    logic reset;
    int   bench_mode;
    int   n_checks;
    int   n_errors;

    truth_table_bist_if #(.N_IN(3)) bif ();

    truth_table_bist #(
        .N_IN    (3),
        .EXPECTED(8'h96),
        .SETTLE  (2)
    ) u_dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Block-under-test models: 0 = 3-input XOR, 1 = stuck-at-0, 2 = stuck-at-1.
    always_comb begin
        bif.dut_out = 1'b0;
        case (bench_mode)
            0:       bif.dut_out = ^bif.dut_in;
            1:       bif.dut_out = 1'b0;
            default: bif.dut_out = 1'b1;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic run_sweep(input string name, input int inj,
                             input logic [7:0] e_tt, input logic [3:0] e_fc,
                             input logic [2:0] e_ff, input logic e_pass);
        int done_at;
        @(negedge clk);
        bif.start = 1'b1;
        @(posedge clk);
        #1;
        bif.start = 1'b0;
        check({name, "_acc_busy"}, 32'(bif.busy), 32'd1);
        check({name, "_acc_done"}, 32'(bif.done), 32'd0);
        check({name, "_acc_tt"}, 32'(bif.tt), 32'd0);
        check({name, "_acc_dut_in"}, 32'(bif.dut_in), 32'd0);
        done_at = -1;
        for (int c = 1; c <= LAT + 8 && done_at < 0; c++) begin
            if (c == inj) bif.start = 1'b1;
            @(posedge clk);
            #1;
            bif.start = 1'b0;
            if (bif.done) done_at = c;
            else begin
                check({name, "_dut_in_step"}, 32'(bif.dut_in), 32'(c / PER));
                check({name, "_busy_hold"}, 32'(bif.busy), 32'd1);
            end
        end
        check({name, "_done_latency"}, 32'(done_at), 32'(LAT));
        check({name, "_tt"}, 32'(bif.tt), 32'(e_tt));
        check({name, "_fail_count"}, 32'(bif.fail_count), 32'(e_fc));
        check({name, "_first_fail"}, 32'(bif.first_fail), 32'(e_ff));
        check({name, "_pass"}, 32'(bif.pass), 32'(e_pass));
        check({name, "_busy_end"}, 32'(bif.busy), 32'd0);
        check({name, "_dut_in_end"}, 32'(bif.dut_in), 32'd7);
    endtask

    function automatic logic [31:0] all_outputs();
        return {13'd0, bif.busy, bif.done, bif.pass, bif.tt, bif.fail_count, bif.first_fail, bif.dut_in};
    endfunction

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        bench_mode = 0;
        reset      = 1'b0;
        bif.start  = 1'b0;

        // Async reset in mid-cycle, no clock edge in between.
        #23;
        reset = 1'b1;
        #1;
        check("reset_async", all_outputs(), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check("idle_quiet", all_outputs(), 32'd0);
        end

        bench_mode = 0;
        run_sweep("xor", 0, 8'h96, 4'd0, 3'd0, 1'b1);

        bench_mode = 1;
        run_sweep("stuck0", 0, 8'h00, 4'd4, 3'd1, 1'b0);

        bench_mode = 0;
        run_sweep("xor_ignore_start", 5, 8'h96, 4'd0, 3'd0, 1'b1);

        // Abort a sweep with reset ten cycles in.
        @(negedge clk);
        bif.start = 1'b1;
        @(posedge clk);
        #1;
        bif.start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("abort_outputs", all_outputs(), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("abort_stay_idle", all_outputs(), 32'd0);

        run_sweep("xor_after_abort", 0, 8'h96, 4'd0, 3'd0, 1'b1);
        run_sweep("xor_restart_done", 0, 8'h96, 4'd0, 3'd0, 1'b1);

        bench_mode = 2;
        run_sweep("stuck1", 0, 8'h00 | 8'hFF, 4'd4, 3'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/truth_table_bist.md
Name: truth_table_bist

Overview:
Self-test controller that sits directly upstream and downstream of a small combinational logic block (N_IN inputs, 1 output).
- Replaces the free-running stimulus counter with a synthesizable sequencer.
- Drives all 2^N_IN input patterns in ascending order and waits a settle time after each.
- Samples the block output and assembles the measured truth table.
- Compares the table against an expected table and reports pass/fail plus diagnostics.

Parameters:
N_IN, 3, number of inputs of the block under test (1..6)
EXPECTED, 8'h96, expected truth table; bit i = required output for input pattern i; width 2^N_IN
SETTLE, 2, cycles the pattern is held before sampling (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
start  input  1  single-cycle request to run one sweep; honoured only in IDLE or DONE
dut_in  output  N_IN  pattern driven to block inputs, MSB = first input
dut_out  input  1  block output
busy  output  1  high while a sweep is in progress
done  output  1  high from sweep completion until next accepted start or reset
pass  output  1  valid when done=1; 1 iff fail_count==0
tt  output  2^N_IN  measured truth table, bit i = sampled dut_out for pattern i
fail_count  output  N_IN+1  number of mismatching patterns (0..2^N_IN)
first_fail  output  N_IN  lowest mismatching pattern; 0 if none

Behaviour:
- Reset (async, active-high): state=IDLE. dut_in, busy, done, pass, tt, fail_count and first_fail all = 0. Settle counter = 0.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE/DONE + start=1 on a clock edge:
  - dut_in<=0, tt<=0, fail_count<=0, first_fail<=0.
  - done<=0, pass<=0, busy<=1.
  - Settle counter<=SETTLE-1; go to SETTLE.
- SETTLE: decrement counter each cycle. When counter==0, go to SAMPLE next cycle. SETTLE lasts exactly SETTLE cycles.
- SAMPLE (one cycle):
  - tt[dut_in]<=dut_out.
  - If dut_out!=EXPECTED[dut_in]: fail_count<=fail_count+1. If this is the first mismatch, first_fail<=dut_in.
  - If dut_in==all-ones: go to DONE; busy<=0, done<=1, pass<=(no mismatch in the whole sweep, including this sample).
  - Otherwise: dut_in<=dut_in+1, reload counter, go to SETTLE.
- Latency: a sweep takes 2^N_IN*(SETTLE+1) cycles from the accepting edge to the edge setting done. Default: 8*3 = 24 cycles.
- dut_in is stable for all SETTLE+1 cycles of each vector. It holds its last value (all-ones) in DONE.
- start while busy=1 is ignored, with no effect on the sweep.
- start in DONE restarts the sweep. done drops on the same edge; tt clears.
- dut_in never wraps within a sweep. The sweep ends at all-ones.
- fail_count saturation is not needed; its width holds 2^N_IN.
- Reset mid-sweep aborts immediately to IDLE with all outputs 0. No partial results are retained.
- Outputs are registered; no combinational path from dut_out to any output.

Optional Feature:
BIST_SYNC_EN
- Defined: dut_out passes through a 2-flop synchronizer (reset to 0) before comparison, and the effective settle becomes SETTLE+2. Sweep = 2^N_IN*(SETTLE+3) cycles; default 40.
- Undefined: dut_out is sampled directly in SAMPLE; timing as above.

Test Plan:
1. Assert reset asynchronously mid-cycle, no start -> all outputs 0 immediately; stay 0 with start=0 for 20 cycles.
2. Bench model dut_out = ^dut_in, EXPECTED=8'h96, pulse start:
   - dut_in steps 0..7, each held 3 cycles.
   - done=1 exactly 24 cycles after the accepting edge.
   - tt=8'h96, fail_count=0, first_fail=0, pass=1.
3. Bench model with dut_out stuck at 0 -> tt=8'h00, fail_count=4, first_fail=3'd1, pass=0, done=1 after 24 cycles.
4. Pulse start again at cycle 5 of a sweep -> ignored; done still at cycle 24. Then assert reset at cycle 10 of a new sweep -> IDLE, busy=0, dut_in=0; a following start runs a complete 24-cycle sweep.
5. In DONE with tt=8'h96, pulse start -> next edge done=0, tt=0, busy=1, dut_in=0; completes again with pass=1.
6. With BIST_SYNC_EN and the XOR model -> done 40 cycles after start, tt=8'h96, pass=1. Stuck-at-1 model -> fail_count=4, first_fail=3'd0.
